// File: rtl/life_pkg.sv
// life_pkg: shared grid type, cell count and controller state encoding
package life_pkg;
  localparam int N_CELLS = 64;
  typedef logic [N_CELLS-1:0] grid_t;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PAUSE = 3'd2,
    RUN   = 3'd3,
    GEN   = 3'd4,
    EVAL  = 3'd5,
    HALT  = 3'd6
  } state_t;
endpackage

// File: rtl/life_if.sv
// life_if: controller <-> Game of Life datapath link
// grid_load/grid_seed: seed transfer; gen_en: advance one generation; grid_in: current grid back from datapath
interface life_if;
  import life_pkg::*;
  grid_t grid_in;
  grid_t grid_seed;
  logic  grid_load;
  logic  gen_en;
  modport master(output grid_load, grid_seed, gen_en, input grid_in);
  modport slave(input grid_load, grid_seed, gen_en, output grid_in);
endinterface

// File: rtl/life_tick_div.sv
// life_tick_div: free-run rate divider, tc high when the count sits at TICK_DIV-1
// clk/reset: clock and async active-low reset; clr: sync clear; en: count enable; tc: terminal count
module life_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tc = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/life_ctrl.sv
// life_ctrl: seed loading, free-run/single-step sequencing and halt detection for the Game of Life datapath
// clk/reset: clock and async active-low reset; seed/load/run/step: board controls;
// dp: datapath link; gen_count: saturating generation count; state: debug state; extinct/stable: sticky halt flags
module life_ctrl
  import life_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  grid_t            seed,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  life_if.master           dp,
  output logic [GEN_W-1:0] gen_count,
  output logic [2:0]       state,
  output logic             extinct,
  output logic             stable
);
  state_t st, nx;
  grid_t  seed_q, prev_q;
  logic   from_step, tc, ext, stb;
  assign dp.grid_load = st == LOAD;
  assign dp.gen_en    = st == GEN;
  assign dp.grid_seed = seed_q;
  assign state        = st;
  assign ext          = dp.grid_in == '0;
  assign stb          = dp.grid_in == prev_q;
  life_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (st != RUN),
    .en   (st == RUN),
    .tc   (tc)
  );
  always_comb begin
    nx = st;
    case (st)
      IDLE:    nx = load ? LOAD : IDLE;
      LOAD:    nx = PAUSE;
      PAUSE:   nx = load ? LOAD : run ? RUN : step ? GEN : PAUSE;
      RUN:     nx = load ? LOAD : !run ? PAUSE : tc ? GEN : RUN;
      GEN:     nx = EVAL;
      EVAL:    nx = (ext || stb) ? HALT : (from_step || !run) ? PAUSE : RUN;
      HALT:    nx = load ? LOAD : HALT;
      default: nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st        <= IDLE;
      seed_q    <= '0;
      prev_q    <= '0;
      from_step <= 1'b0;
      gen_count <= '0;
      extinct   <= 1'b0;
      stable    <= 1'b0;
    end else begin
      st <= nx;
      if (nx == LOAD) seed_q <= seed;
      if (nx == GEN) from_step <= st == PAUSE;
      if (st == GEN) prev_q <= dp.grid_in;
      if (st == LOAD) begin
        gen_count <= '0;
        extinct   <= 1'b0;
        stable    <= 1'b0;
      end
      if (st == EVAL) begin
        if (gen_count != '1) gen_count <= gen_count + GEN_W'(1);
        extinct <= ext;
        stable  <= stb;
      end
    end
endmodule

// File: tb/tb_life_ctrl.sv
// tb_life_ctrl: scoreboard bench for life_ctrl with a behavioural Game of Life datapath and reference model
module tb_life_ctrl;
  import life_pkg::*;
  localparam int TD = 4;

  logic  clk = 0, reset = 1, load = 0, run = 0, step = 0;
  grid_t seed = '0;
  always #5 clk = ~clk;

  life_if if0();
  life_if if1();
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic [2:0]  st0, st1;
  logic        ext0, ext1, stb0, stb1;
  grid_t       g0, g1;

  life_ctrl #(.TICK_DIV(TD), .GEN_W(16)) dut0 (
    .clk(clk), .reset(reset), .seed(seed), .load(load), .run(run), .step(step),
    .dp(if0), .gen_count(cnt0), .state(st0), .extinct(ext0), .stable(stb0));
  life_ctrl #(.TICK_DIV(TD), .GEN_W(2)) dut1 (
    .clk(clk), .reset(reset), .seed(seed), .load(load), .run(run), .step(step),
    .dp(if1), .gen_count(cnt1), .state(st1), .extinct(ext1), .stable(stb1));

  function automatic grid_t life_next(grid_t g);
    grid_t n;
    int k;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              k += int'(g[(r + dr) * 8 + c + dc]);
        n[r * 8 + c] = (k == 3) || (k == 2 && g[r * 8 + c]);
      end
    return n;
  endfunction

  assign if0.grid_in = g0;
  assign if1.grid_in = g1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      g0 <= '0;
      g1 <= '0;
    end else begin
      if (if0.grid_load) g0 <= if0.grid_seed;
      else if (if0.gen_en) g0 <= life_next(g0);
      if (if1.grid_load) g1 <= if1.grid_seed;
      else if (if1.gen_en) g1 <= life_next(g1);
    end

  typedef struct {
    grid_t grid;
    int    cnt;
    int    cnt2;
    logic  ext;
    logic  stb;
  } exp_t;
  exp_t  exp_q[$];
  int    tests = 0, fails = 0;
  grid_t m_grid = '0;
  int    m_cnt = 0;
  bit    m_halt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push_gen();
    exp_t  e;
    grid_t n;
    n = life_next(m_grid);
    m_cnt++;
    e.grid = n;
    e.cnt  = m_cnt > 65535 ? 65535 : m_cnt;
    e.cnt2 = m_cnt > 3 ? 3 : m_cnt;
    e.ext  = n == '0;
    e.stb  = n == m_grid;
    m_halt = e.ext || e.stb;
    m_grid = n;
    exp_q.push_back(e);
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if0.gen_en) begin
        chk("gen_en_lockstep", if1.gen_en, 1);
        if (exp_q.size() == 0) chk("gen_en_unexpected", if0.gen_en, 0);
        else begin
          e = exp_q.pop_front();
          @(negedge clk);
          chk("grid0", g0, e.grid);
          chk("grid1", g1, e.grid);
          @(negedge clk);
          chk("gen_count16", cnt0, e.cnt);
          chk("gen_count2", cnt1, e.cnt2);
          chk("extinct0", ext0, e.ext);
          chk("stable0", stb0, e.stb);
          chk("extinct1", ext1, e.ext);
          chk("stable1", stb1, e.stb);
        end
      end
    end
  end

  task automatic wait_gen(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!if0.gen_en && c < 100);
    chk("gen_en_timeout", if0.gen_en, 1);
  endtask

  task automatic load_seed(input grid_t s);
    int c;
    @(negedge clk);
    seed = s;
    load = 1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!if0.grid_load && c < 20);
    chk("grid_load", if0.grid_load, 1);
    chk("grid_seed", if0.grid_seed, s);
    chk("load_state", st0, 1);
    load = 0;
    m_grid = s;
    m_cnt = 0;
    m_halt = 0;
    @(negedge clk);
    chk("load_cnt_clr", cnt0, 0);
    chk("load_ext_clr", ext0, 0);
    chk("load_stb_clr", stb0, 0);
    chk("load_to_pause", st0, 2);
  endtask

  task automatic do_step();
    @(negedge clk);
    if (!m_halt) push_gen();
    step = 1;
    @(negedge clk);
    step = 0;
    repeat (2) @(negedge clk);
    chk("step_state", st0, m_halt ? 6 : 2);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_gens(input int n);
    int c, k;
    k = 0;
    @(negedge clk);
    while (k < n && !m_halt) begin
      push_gen();
      k++;
    end
    run = 1;
    for (int i = 0; i < k; i++) begin
      wait_gen(c);
      chk(i == 0 ? "run_first_gap" : "run_period", c, i == 0 ? TD + 1 : TD + 2);
    end
    run = 0;
    if (k == 0) repeat (10) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("run_state", st0, m_halt ? 6 : 2);
  endtask

  initial begin
    int c;
    #2 reset = 0;
    repeat (2) @(negedge clk);
    chk("rst_grid_load", if0.grid_load, 0);
    chk("rst_gen_en", if0.gen_en, 0);
    chk("rst_grid_seed", if0.grid_seed, 0);
    chk("rst_gen_count", cnt0, 0);
    chk("rst_state", st0, 0);
    chk("rst_extinct", ext0, 0);
    chk("rst_stable", stb0, 0);
    reset = 1;
    repeat (2) @(negedge clk);

    load_seed(64'h0000_0000_0303_0000);
    do_step();
    chk("block_state", st0, 6);
    chk("block_stable", stb0, 1);
    chk("block_extinct", ext0, 0);
    chk("block_count", cnt0, 1);

    load_seed(64'h1);
    run_gens(5);
    chk("single_extinct", ext0, 1);
    chk("single_stable", stb0, 0);
    chk("single_count", cnt0, 1);
    run_gens(3);
    do_step();
    chk("single_held_state", st0, 6);
    chk("single_held_count", cnt0, 1);

    load_seed(64'h0);
    do_step();
    chk("zero_extinct", ext0, 1);
    chk("zero_stable", stb0, 1);

    load_seed(64'h0000_0000_0007_0000);
    run_gens(10);
    chk("blinker_count16", cnt0, 10);
    chk("blinker_count2", cnt1, 3);
    chk("blinker_flags", {ext0, stb0}, 0);
    chk("blinker_grid", g0, 64'h0000_0000_0007_0000);

    @(negedge clk);
    push_gen();
    run = 1;
    wait_gen(c);
    repeat (3) @(negedge clk);
    seed = 64'h1;
    load = 1;
    @(negedge clk);
    chk("midtick_state", st0, 1);
    chk("midtick_grid_load", if0.grid_load, 1);
    chk("midtick_grid_seed", if0.grid_seed, 64'h1);
    load = 0;
    run = 0;
    m_grid = 64'h1;
    m_cnt = 0;
    m_halt = 0;
    @(negedge clk);
    chk("midtick_count", cnt0, 0);
    chk("midtick_flags", {ext0, stb0}, 0);
    chk("midtick_pause", st0, 2);

    for (int t = 0; t < 6; t++) begin
      load_seed({$urandom & $urandom, $urandom & $urandom});
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 1) == 1) do_step();
        else run_gens($urandom_range(1, 4));
    end

    load_seed(64'h0000_0000_0007_0000);
    run_gens(2);
    @(negedge clk);
    step = 1;
    @(posedge clk);
    #1 chk("pre_reset_gen_en", if0.gen_en, 1);
    reset = 0;
    #1;
    chk("async_gen_en", if0.gen_en, 0);
    chk("async_grid_load", if0.grid_load, 0);
    chk("async_grid_seed", if0.grid_seed, 0);
    chk("async_count", cnt0, 0);
    chk("async_state", st0, 0);
    chk("async_flags", {ext0, stb0}, 0);
    step = 0;
    @(negedge clk);
    reset = 1;
    run = 1;
    repeat (15) begin
      @(negedge clk);
      step = ~step;
    end
    step = 0;
    run = 0;
    @(negedge clk);
    chk("idle_after_reset", st0, 0);
    chk("idle_count", cnt0, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
